// File: rtl/fifo_mem_ctrl_if.sv
// User-side handshake bundle for fifo_mem_ctrl: push/pop requests, read data and status flags.
// master = FIFO user, slave = controller.
interface fifo_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) ();

  logic              push;
  logic [DATA_W-1:0] wr_data;
  logic              pop;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output push,
    output wr_data,
    output pop,
    input  rd_data,
    input  rd_valid,
    input  full,
    input  empty,
    input  almost_full,
    input  count,
    input  overflow,
    input  underflow
  );

  modport slave (
    input  push,
    input  wr_data,
    input  pop,
    output rd_data,
    output rd_valid,
    output full,
    output empty,
    output almost_full,
    output count,
    output overflow,
    output underflow
  );

endinterface

// File: rtl/fifo_mem_ctrl.sv
// Single-clock FIFO controller using an external dual-port sync_mem as storage.
// Port 1 carries writes at wr_ptr, port 2 reads at rd_ptr; the memory registers both addresses.
module fifo_mem_ctrl #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AF_LEVEL = 240
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_mem_ctrl_if.slave     bus,
  output logic [ADDR_W-1:0]  mem_a1,
  output logic [DATA_W-1:0]  mem_wd1,
  output logic               mem_we1,
  output logic               mem_we2,
  output logic [ADDR_W-1:0]  mem_a2,
  input  logic [DATA_W-1:0]  mem_rd2
);

  localparam logic [ADDR_W:0] Depth   = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] AfLevel = (ADDR_W+1)'(AF_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   cnt_q;
  logic              rd_valid_q;
  logic              overflow_q;
  logic              underflow_q;

  logic full;
  logic empty;
  logic push_acc;
  logic pop_acc;

  always_comb begin
    full  = (cnt_q == Depth);
    empty = (cnt_q == '0);
    // Push while full is refused even with a concurrent pop: wr_ptr == rd_ptr then.
    push_acc = rst_n & bus.push & ~full;
    pop_acc  = rst_n & bus.pop & ~empty;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_acc)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q       <= cnt_q + (ADDR_W+1)'(push_acc) - (ADDR_W+1)'(pop_acc);
      rd_valid_q  <= pop_acc;
      overflow_q  <= overflow_q | (bus.push & full);
      underflow_q <= underflow_q | (bus.pop & empty);
    end
  end

  assign mem_a1  = wr_ptr_q;
  assign mem_wd1 = bus.wr_data;
  assign mem_we1 = push_acc;
  assign mem_we2 = 1'b0;
  assign mem_a2  = rd_ptr_q;

  assign bus.rd_data     = mem_rd2;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = (cnt_q >= AfLevel);
  assign bus.count       = cnt_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Randomised and directed bench for fifo_mem_ctrl against a queue-based FIFO model,
// with a behavioural sync_mem (registered read address) attached to the memory ports.
module tb_fifo_mem_ctrl;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned AF    = 240;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] mem_a1;
  logic [DW-1:0] mem_wd1;
  logic          mem_we1;
  logic          mem_we2;
  logic [AW-1:0] mem_a2;
  logic [DW-1:0] mem_rd2;

  fifo_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  fifo_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .AF_LEVEL(AF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .mem_a1  (mem_a1),
    .mem_wd1 (mem_wd1),
    .mem_we1 (mem_we1),
    .mem_we2 (mem_we2),
    .mem_a2  (mem_a2),
    .mem_rd2 (mem_rd2)
  );

  // sync_mem stand-in: write and read address registered on the rising edge.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] a2_q;
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    a2_q = '0;
  end
  always @(posedge clk) begin
    if (mem_we1) mem[mem_a1] <= mem_wd1;
    a2_q <= mem_a2;
  end
  assign mem_rd2 = mem[a2_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, sticky flags, expected read result.
  logic [DW-1:0] model_q [$];
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            m_rv  = 1'b0;
  logic [DW-1:0] m_rd  = '0;

  task automatic cycle(input bit p, input logic [DW-1:0] d, input bit q, input bit rn);
    bit acc_push;
    bit acc_pop;
    bit was_full;
    bit was_empty;
    rst_n       = rn;
    bus.push    = p;
    bus.wr_data = d;
    bus.pop     = q;
    was_full  = (model_q.size() == DEPTH);
    was_empty = (model_q.size() == 0);
    acc_push  = rn && p && !was_full;
    acc_pop   = rn && q && !was_empty;
    #1;
    check("mem_we1", 32'(mem_we1), 32'(acc_push));
    check("mem_we2", 32'(mem_we2), 32'd0);
    if (acc_push) check("mem_wd1", 32'(mem_wd1), 32'(d));
    @(posedge clk);
    #1;
    if (!rn) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      m_ovf = m_ovf | (p && was_full);
      m_udf = m_udf | (q && was_empty);
      m_rv  = acc_pop;
      if (acc_pop)  m_rd = model_q.pop_front();
      if (acc_push) model_q.push_back(d);
    end
    check("count",       32'(bus.count),       32'(model_q.size()));
    check("empty",       32'(bus.empty),       32'(model_q.size() == 0));
    check("full",        32'(bus.full),        32'(model_q.size() == DEPTH));
    check("almost_full", 32'(bus.almost_full), 32'(model_q.size() >= AF));
    check("overflow",    32'(bus.overflow),    32'(m_ovf));
    check("underflow",   32'(bus.underflow),   32'(m_udf));
    check("rd_valid",    32'(bus.rd_valid),    32'(m_rv));
    if (m_rv) check("rd_data", 32'(bus.rd_data), 32'(m_rd));
  endtask

  initial begin
    logic [DW-1:0] wd;
    int bias_push;
    int bias_pop;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.wr_data = '0;

    // Reset, then idle.
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    repeat (3) cycle(0, 8'h00, 0, 1);

    // Single word round trip.
    cycle(1, 8'hA5, 0, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    check("a5_empty_again", 32'(bus.empty), 32'd1);

    // Fill completely, overflow attempt, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1, DW'(i), 0, 1);
    check("filled_full", 32'(bus.full), 32'd1);
    cycle(1, 8'h77, 0, 1);
    check("ovf_count", 32'(bus.count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);

    // Prefill 10, then streaming push+pop across pointer wrap.
    cycle(0, 8'h00, 0, 0);
    wd = 8'h00;
    for (int i = 0; i < 10; i++) begin
      cycle(1, wd, 0, 1);
      wd++;
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1, wd, 1, 1);
      wd++;
    end
    check("stream_count", 32'(bus.count), 32'd10);
    for (int i = 0; i < 10; i++) cycle(0, 8'h00, 1, 1);

    // Simultaneous push/pop on empty: pop refused.
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'h3C, 1, 1);
    check("empty_pp_count", 32'(bus.count), 32'd1);
    cycle(0, 8'h00, 0, 1);

    // Fill to full, simultaneous push/pop: push refused; then reset mid-stream.
    for (int i = 1; i < DEPTH; i++) cycle(1, DW'(i ^ 8'h5A), 0, 1);
    cycle(1, 8'hEE, 1, 1);
    check("full_pp_count", 32'(bus.count), 32'(DEPTH - 1));
    cycle(0, 8'h00, 1, 1);
    cycle(1, 8'h99, 1, 0);
    check("rst_count", 32'(bus.count), 32'd0);
    cycle(0, 8'h00, 0, 1);

    // Random traffic in epochs with shifting push/pop bias; rare resets.
    for (int e = 0; e < 12; e++) begin
      bias_push = (e % 3 == 0) ? 85 : ((e % 3 == 1) ? 20 : 55);
      bias_pop  = (e % 3 == 0) ? 15 : ((e % 3 == 1) ? 80 : 50);
      for (int i = 0; i < 350; i++) begin
        cycle($urandom_range(0, 99) < bias_push, DW'($urandom),
              $urandom_range(0, 99) < bias_pop, $urandom_range(0, 499) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_mem_ctrl.md
Name: fifo_mem_ctrl

Overview:
- Single-clock synchronous FIFO controller that drives the dual-port sync_mem macro as its storage.
- Write side uses memory port 1 (A1/WD1/WE1); read side uses port 2 (A2/RD2).
- Provides push/pop handshakes, occupancy flags and error flags to the FIFO user.
- Sits between the FIFO user logic and sync_mem; it is the initiator for that memory's registered-address interface.

Parameters:
ADDR_W, 8, memory address width; FIFO depth = 2**ADDR_W entries (256).
DATA_W, 8, data word width; must match memory word width.
AF_LEVEL, 240, occupancy at or above which almost_full is asserted; legal range 1..2**ADDR_W.

Ports:
clk  input  1  single clock, rising edge; also drives sync_mem clk1 and clk2.
rst_n  input  1  synchronous active-low reset.
push  input  1  write request.
wr_data  input  DATA_W  write data, sampled with push.
pop  input  1  read request.
rd_data  output  DATA_W  read data, combinational pass-through of mem_rd2.
rd_valid  output  1  registered; high for one cycle when rd_data holds a popped word.
full  output  1  count == 2**ADDR_W.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_LEVEL.
count  output  ADDR_W+1  current occupancy.
overflow  output  1  sticky; set when push occurs while full.
underflow  output  1  sticky; set when pop occurs while empty.
mem_a1  output  ADDR_W  to sync_mem A1; equals wr_ptr.
mem_wd1  output  DATA_W  to sync_mem WD1; equals wr_data.
mem_we1  output  1  to sync_mem WE1; equals push_acc.
mem_we2  output  1  to sync_mem WE2; tied 0.
mem_a2  output  ADDR_W  to sync_mem A2; equals rd_ptr.
mem_rd2  input  DATA_W  from sync_mem RD2.

Behaviour:
- Internal registers: wr_ptr and rd_ptr (ADDR_W bits each, natural wrap from 2**ADDR_W-1 to 0), cnt (ADDR_W+1 bits), rd_valid, overflow, underflow.
- Acceptance:
  - push_acc = rst_n & push & !full.
  - pop_acc = rst_n & pop & !empty.
  - Flags are evaluated on the registered count at the start of the cycle.
- Push while full is always rejected, even if pop_acc is high in the same cycle.
  - Reason: when full, wr_ptr == rd_ptr, so a same-edge write would corrupt the word being read.
- Pop while empty is always rejected, even if push is accepted in the same cycle.
- On each rising edge with rst_n=1:
  - push_acc: wr_ptr += 1.
  - pop_acc: rd_ptr += 1.
  - cnt += push_acc - pop_acc; push and pop accepted together leave cnt unchanged.
  - rd_valid <= pop_acc.
  - overflow |= push & full.
  - underflow |= pop & empty.
- Memory timing:
  - Memory port signals are combinational; sync_mem registers them on the same edge that updates the pointers.
  - Write latency: a word pushed in cycle N is in memory after edge N+1.
  - Earliest pop of that word is cycle N+1, when empty is already low; no read-after-write hazard.
- Read latency: pop accepted in cycle N -> rd_valid=1 and rd_data = popped word in cycle N+1. Back-to-back pops give one word per cycle.
- rd_data is undefined whenever rd_valid=0.
- Reset (rst_n=0 at a rising edge):
  - wr_ptr=0, rd_ptr=0, cnt=0, rd_valid=0, overflow=0, underflow=0.
  - Resulting outputs: empty=1, full=0, almost_full=0 (AF_LEVEL >= 1).
  - While rst_n=0, mem_we1 is forced 0, so an in-flight push is dropped.
  - Memory contents are not cleared. Reset mid-operation discards all stored words; a pending rd_valid is cleared.
- Flags:
  - full, empty and almost_full are combinational decodes of cnt, so they update in the cycle after the causing edge.
  - overflow and underflow clear only on reset.

Test Plan:
- Reset, then idle 3 cycles -> empty=1, full=0, count=0, rd_valid=0, mem_we1=0, overflow=0, underflow=0.
- Push 0xA5 in cycle 1; pop in cycle 2 -> count=1 after cycle 1; rd_valid=1 with rd_data=0xA5 in cycle 3; empty=1 again in cycle 3.
- Push 0x00..0xFF in 256 consecutive cycles -> almost_full rises when count reaches 240; full=1 at count=256. Push 0x77 -> rejected, overflow=1, count stays 256. Pop 256 times -> rd_data sequence 0x00..0xFF.
- Prefill 10 words, then push and pop simultaneously for 300 cycles with wr_data incrementing -> count holds at 10; pointers wrap past 255; read order is strictly sequential with no loss.
- Empty FIFO with push=1 and pop=1 in the same cycle -> push accepted, pop rejected, underflow=1, count=1, rd_valid=0 next cycle.
- Full FIFO with push=1 and pop=1 -> pop accepted, push rejected, overflow=1, count=255. Then assert rst_n=0 for one cycle mid-stream with push=1 -> count=0, empty=1, rd_valid=0, both error flags cleared.
